// File: rtl/alu32_selftest_if.sv
// Operand/result bus between the ALU self-test sequencer (master) and the
// 32-bit add/sub ALU under test (slave).
interface alu32_selftest_if;
  logic        alu_sub_add;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic        alu_carry;
  logic        alu_zero;
  logic        alu_overflow;

  modport master (
    output alu_sub_add, alu_a, alu_b,
    input  alu_result, alu_carry, alu_zero, alu_overflow
  );

  modport slave (
    input  alu_sub_add, alu_a, alu_b,
    output alu_result, alu_carry, alu_zero, alu_overflow
  );
endinterface

// File: rtl/alu32_selftest.sv
// On-board self-test for the 32-bit add/sub ALU: drives corner then LFSR vectors,
// checks result and flags, counts errors. Option: ALU32_STOP_ON_FAIL_EN ends the run on the first mismatch.
module alu32_selftest #(
  parameter int unsigned NUM_VECTORS = 64,
  parameter int unsigned CHECK_DELAY = 1,
  parameter logic [31:0] SEED        = 32'hACE12024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  alu32_selftest_if.master         alu,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [15:0]              vec_count,
  output logic [15:0]              err_count,
  output logic [15:0]              fail_index,
  output logic [3:0]               fail_mask
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] DRIVE = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] CHECK = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam logic [15:0] LAST_INDEX = 16'(NUM_VECTORS - 1);
  localparam logic [2:0]  WAIT_LOAD  = (CHECK_DELAY == 0) ? 3'd0 : 3'(CHECK_DELAY - 1);

  logic [2:0]  state;
  logic [2:0]  waitCnt;
  logic [31:0] lfsr;
  logic [31:0] lfsrNext;

  logic        nextSub;
  logic [31:0] nextA;
  logic [31:0] nextB;

  logic [31:0] bEff;
  logic [32:0] expSum;
  logic        expZero;
  logic        expOverflow;
  logic [3:0]  mismatch;
  logic        lastVector;
  logic        endRun;

  // Fibonacci LFSR, taps 32,22,2,1, shifting left.
  assign lfsrNext = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};

  // NOTE: every always_comb output gets a default first so that no path
  // through the case can leave it unassigned and infer a latch.
  always_comb begin
    nextSub = lfsr[0] ^ lfsr[31];
    nextA   = lfsr;
    nextB   = {lfsr[18:0], lfsr[31:19]} ^ 32'h5A5A5A5A;
    case (vec_count)
      16'd0: begin nextSub = 1'b0; nextA = 32'h00000000; nextB = 32'h00000000; end
      16'd1: begin nextSub = 1'b0; nextA = 32'h7FFFFFFF; nextB = 32'h00000001; end
      16'd2: begin nextSub = 1'b1; nextA = 32'h80000000; nextB = 32'h00000001; end
      16'd3: begin nextSub = 1'b1; nextA = 32'h12345678; nextB = 32'h12345678; end
      default: ;
    endcase
  end

  // Reference model evaluated on the registered operands the ALU is seeing.
  assign bEff        = alu.alu_sub_add ? ~alu.alu_b : alu.alu_b;
  assign expSum      = {1'b0, alu.alu_a} + {1'b0, bEff} + {32'd0, alu.alu_sub_add};
  assign expZero     = (expSum[31:0] == 32'd0);
  assign expOverflow = (alu.alu_a[31] == bEff[31]) && (expSum[31] != alu.alu_a[31]);

  assign mismatch = {alu.alu_result   != expSum[31:0],
                     alu.alu_carry    != expSum[32],
                     alu.alu_zero     != expZero,
                     alu.alu_overflow != expOverflow};

  assign lastVector = (vec_count == LAST_INDEX);

`ifdef ALU32_STOP_ON_FAIL_EN
  assign endRun = lastVector || (|mismatch);
`else
  assign endRun = lastVector;
`endif

  assign pass = done && (err_count == 16'd0);

  // NOTE: all state here uses non-blocking assignment so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      waitCnt         <= 3'd0;
      lfsr            <= SEED;
      busy            <= 1'b0;
      done            <= 1'b0;
      vec_count       <= 16'd0;
      err_count       <= 16'd0;
      fail_index      <= 16'd0;
      fail_mask       <= 4'd0;
      alu.alu_sub_add <= 1'b0;
      alu.alu_a       <= 32'd0;
      alu.alu_b       <= 32'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            vec_count  <= 16'd0;
            err_count  <= 16'd0;
            fail_index <= 16'd0;
            fail_mask  <= 4'd0;
            lfsr       <= SEED;
            busy       <= 1'b1;
            done       <= 1'b0;
            state      <= DRIVE;
          end
        end

        DRIVE: begin
          alu.alu_sub_add <= nextSub;
          alu.alu_a       <= nextA;
          alu.alu_b       <= nextB;
          lfsr            <= lfsrNext;
          if (CHECK_DELAY == 0) begin
            state <= CHECK;
          end else begin
            waitCnt <= WAIT_LOAD;
            state   <= WAIT;
          end
        end

        WAIT: begin
          if (waitCnt == 3'd0) begin
            state <= CHECK;
          end else begin
            waitCnt <= waitCnt - 3'd1;
          end
        end

        CHECK: begin
          vec_count <= vec_count + 16'd1;
          if (|mismatch) begin
            if (err_count != 16'hFFFF) begin
              err_count <= err_count + 16'd1;
            end
            // Only the first failing vector is recorded.
            if (err_count == 16'd0) begin
              fail_index <= vec_count;
              fail_mask  <= mismatch;
            end
          end
          if (endRun) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            state <= DRIVE;
          end
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu32_selftest.sv
// Scoreboard bench for alu32_selftest: a behavioural ALU with an injectable zero-flag fault,
// expected vectors and end-of-run status queued by the stimulus, popped by a monitor.
module tb_alu32_selftest;

  localparam int          NUM  = 16;
  localparam int          CD   = 1;
  localparam logic [31:0] SEED = 32'hACE12024;
  localparam int          RUN_LATENCY = NUM * (2 + CD);

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
  } vec_t;

  typedef struct {
    logic [15:0] vecCount;
    logic [15:0] errCount;
    logic [15:0] failIndex;
    logic [3:0]  failMask;
    logic        pass;
    logic        busy;
    logic        done;
    vec_t        alu;
    int          latency;
  } status_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic zeroStuck = 1'b0;

  logic        busy, done, pass;
  logic [15:0] vec_count, err_count, fail_index;
  logic [3:0]  fail_mask;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int runStart = 0;

  vec_t    vecQ[$];
  status_t doneQ[$];
  status_t rstQ[$];

  alu32_selftest_if aluBus ();

  alu32_selftest #(
    .NUM_VECTORS(NUM),
    .CHECK_DELAY(CD),
    .SEED       (SEED)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .alu       (aluBus),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .vec_count (vec_count),
    .err_count (err_count),
    .fail_index(fail_index),
    .fail_mask (fail_mask)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Behavioural ALU: subtraction written directly, carry = no-borrow.
  logic [32:0] addSum;
  logic [31:0] res;
  always_comb begin
    addSum = {1'b0, aluBus.alu_a} + {1'b0, aluBus.alu_b};
    res    = aluBus.alu_sub_add ? (aluBus.alu_a - aluBus.alu_b) : addSum[31:0];
    aluBus.alu_result = res;
    aluBus.alu_carry  = aluBus.alu_sub_add ? (aluBus.alu_a >= aluBus.alu_b) : addSum[32];
    aluBus.alu_zero   = zeroStuck ? 1'b0 : (res == 32'd0);
    if (aluBus.alu_sub_add)
      aluBus.alu_overflow = (aluBus.alu_a[31] != aluBus.alu_b[31]) && (res[31] != aluBus.alu_a[31]);
    else
      aluBus.alu_overflow = (aluBus.alu_a[31] == aluBus.alu_b[31]) && (res[31] != aluBus.alu_a[31]);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lfsrStep(input logic [31:0] s);
    return {s[30:0], ^(s & 32'h80200003)};
  endfunction

  // Queue the expected operands of the first n vectors; return the last one.
  task automatic pushRun(input int n, output vec_t last);
    logic [31:0] s;
    vec_t v;
    s = SEED;
    for (int i = 0; i < n; i++) begin
      case (i)
        0:       v = '{a: 32'h00000000, b: 32'h00000000, sub: 1'b0};
        1:       v = '{a: 32'h7FFFFFFF, b: 32'h00000001, sub: 1'b0};
        2:       v = '{a: 32'h80000000, b: 32'h00000001, sub: 1'b1};
        3:       v = '{a: 32'h12345678, b: 32'h12345678, sub: 1'b1};
        default: v = '{a: s, b: ((s << 13) | (s >> 19)) ^ 32'h5A5A5A5A, sub: s[0] ^ s[31]};
      endcase
      vecQ.push_back(v);
      last = v;
      s = lfsrStep(s);
    end
  endtask

  function automatic status_t mkStatus(input int vc, input int ec, input int fi, input int fm,
                                       input logic p, input logic d, input vec_t v, input int lat);
    status_t st;
    st.vecCount = 16'(vc);
    st.errCount = 16'(ec);
    st.failIndex = 16'(fi);
    st.failMask = 4'(fm);
    st.pass = p;
    st.busy = 1'b0;
    st.done = d;
    st.alu = v;
    st.latency = lat;
    return st;
  endfunction

  task automatic compareStatus(input string tag, input status_t e);
    check({tag, "_vec_count"},  32'(vec_count),  32'(e.vecCount));
    check({tag, "_err_count"},  32'(err_count),  32'(e.errCount));
    check({tag, "_fail_index"}, 32'(fail_index), 32'(e.failIndex));
    check({tag, "_fail_mask"},  32'(fail_mask),  32'(e.failMask));
    check({tag, "_pass"},       32'(pass),       32'(e.pass));
    check({tag, "_busy"},       32'(busy),       32'(e.busy));
    check({tag, "_done"},       32'(done),       32'(e.done));
    check({tag, "_alu_a"},      aluBus.alu_a,    e.alu.a);
    check({tag, "_alu_b"},      aluBus.alu_b,    e.alu.b);
    check({tag, "_alu_sub"},    32'(aluBus.alu_sub_add), 32'(e.alu.sub));
    if (e.latency >= 0)
      check({tag, "_latency"},  32'(cycle - runStart), 32'(e.latency));
  endtask

  // Monitor: vector checks on each vec_count step, status on done rise and reset release.
  initial begin
    logic [15:0] prevVec = 16'd0;
    logic prevDone = 1'b0;
    logic prevRst = 1'b0;
    vec_t v;
    forever begin
      @(negedge clk);
      if (vec_count == prevVec + 16'd1) begin
        if (vecQ.size() == 0) begin
          checks++; errors++;
          $display("FAIL vec_unexpected: vector %0d checked with none expected", vec_count);
        end else begin
          v = vecQ.pop_front();
          check($sformatf("vec%0d_a", prevVec), aluBus.alu_a, v.a);
          check($sformatf("vec%0d_b", prevVec), aluBus.alu_b, v.b);
          check($sformatf("vec%0d_sub", prevVec), 32'(aluBus.alu_sub_add), 32'(v.sub));
        end
      end
      if (done && !prevDone) begin
        if (doneQ.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_unexpected: done rose with no run expected");
        end else begin
          compareStatus("done", doneQ.pop_front());
        end
      end
      if (rst_n && !prevRst && rstQ.size() != 0)
        compareStatus("reset", rstQ.pop_front());
      prevVec = vec_count;
      prevDone = done;
      prevRst = rst_n;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseStart(input bit newRun);
    start = 1'b1;
    tick();
    if (newRun) runStart = cycle;
    start = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    check("done_within_budget", 32'(done), 32'd1);
  endtask

  task automatic waitVec(input int target, input int budget);
    int n = 0;
    while (int'(vec_count) != target && n < budget) begin
      tick();
      n++;
    end
    check($sformatf("reach_vec%0d", target), 32'(vec_count), 32'(target));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t last;
    vec_t zeroVec;
    zeroVec = '{a: 32'd0, b: 32'd0, sub: 1'b0};

    // Reset state
    rstQ.push_back(mkStatus(0, 0, 0, 0, 1'b0, 1'b0, zeroVec, -1));
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Clean run with golden ALU
    pushRun(NUM, last);
    doneQ.push_back(mkStatus(NUM, 0, 0, 0, 1'b1, 1'b1, last, RUN_LATENCY));
    pulseStart(1'b1);
    waitDone(400);
    tick();

    // Zero flag stuck low: vectors 0 and 3 fail on the zero field
    zeroStuck = 1'b1;
`ifdef ALU32_STOP_ON_FAIL_EN
    pushRun(1, last);
    doneQ.push_back(mkStatus(1, 1, 0, 4'b0010, 1'b0, 1'b1, last, 3));
`else
    pushRun(NUM, last);
    doneQ.push_back(mkStatus(NUM, 2, 0, 4'b0010, 1'b0, 1'b1, last, RUN_LATENCY));
`endif
    pulseStart(1'b1);
    waitDone(400);
    tick();
    zeroStuck = 1'b0;

    // Reset during WAIT of vector 5
    pushRun(5, last);
    pulseStart(1'b1);
    waitVec(5, 100);
    tick();
    rst_n = 1'b0;
    rstQ.push_back(mkStatus(0, 0, 0, 0, 1'b0, 1'b0, zeroVec, -1));
    tick();
    rst_n = 1'b1;
    tick();

    // Fresh run after reset, with a start pulse mid-run that must be ignored
    pushRun(NUM, last);
    doneQ.push_back(mkStatus(NUM, 0, 0, 0, 1'b1, 1'b1, last, RUN_LATENCY));
    pulseStart(1'b1);
    waitVec(3, 100);
    pulseStart(1'b0);
    waitDone(400);
    tick();

    // Restart from DONE reproduces the same sequence
    pushRun(NUM, last);
    doneQ.push_back(mkStatus(NUM, 0, 0, 0, 1'b1, 1'b1, last, RUN_LATENCY));
    pulseStart(1'b1);
    waitDone(400);
    tick();
    tick();

    check("vec_queue_drained",   32'(vecQ.size()),  32'd0);
    check("done_queue_drained",  32'(doneQ.size()), 32'd0);
    check("reset_queue_drained", 32'(rstQ.size()),  32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu32_selftest.md
Name: alu32_selftest

Overview:
Sequential stimulus generator and checker that drives the 32-bit add/sub ALU's operand inputs and checks its result and flag outputs.
- On `start` it applies 4 fixed corner vectors, then LFSR-generated vectors.
- It computes the expected result, carry, zero and overflow internally and compares them to the ALU outputs.
- It counts mismatches and captures the first failure.
- It is the on-board self-test wrapper placed around the ALU for the DCE03 FPGA bring-up.

Parameters:
NUM_VECTORS, 64, total vectors per run including the 4 corner vectors; legal range 4..65535.
CHECK_DELAY, 1, cycles waited between driving operands and sampling ALU outputs; legal range 0..7.
SEED, 32'hACE12024, LFSR load value at start; must be nonzero.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active-low
start  in  1  one-cycle pulse; begins a run
alu_sub_add  out  1  operation to ALU; 0 = add, 1 = sub
alu_a  out  32  operand a to ALU
alu_b  out  32  operand b to ALU
alu_result  in  32  ALU result
alu_carry  in  1  ALU carry flag
alu_zero  in  1  ALU zero flag
alu_overflow  in  1  ALU overflow flag
busy  out  1  run in progress
done  out  1  run finished; held until the next start or reset
pass  out  1  equals done AND (err_count == 0)
vec_count  out  16  vectors checked so far
err_count  out  16  mismatching vectors; saturates at 16'hFFFF
fail_index  out  16  index of the first failing vector
fail_mask  out  4  mismatched fields of the first failure; bits {result, carry, zero, overflow}

Behaviour:
- Reset (rst_n low at a clk edge):
  - State goes to IDLE.
  - All outputs return to 0.
  - LFSR loads SEED.
  - Applies in any state, mid-run included; the run is abandoned with no residue.
- FSM states: IDLE, DRIVE, WAIT, CHECK, DONE.
- IDLE or DONE, start=1:
  - Clear vec_count, err_count, fail_index and fail_mask; reload the LFSR.
  - Go to DRIVE; busy=1, done=0.
- start while busy is ignored.
- DRIVE (1 cycle): register alu_sub_add, alu_a and alu_b for vector index i = vec_count.
  - i=0: a=0, b=0, add.
  - i=1: a=32'h7FFFFFFF, b=1, add.
  - i=2: a=32'h80000000, b=1, sub.
  - i=3: a=b=32'h12345678, sub.
  - i>=4: a=lfsr, b={lfsr[18:0],lfsr[31:19]}^32'h5A5A5A5A, sub=lfsr[0]^lfsr[31].
  - The LFSR steps once per DRIVE. Taps are 32,22,2,1, in Fibonacci form shifting left.
  - For i<4 the LFSR still steps.
- WAIT: hold operands stable for CHECK_DELAY cycles; state is skipped when CHECK_DELAY=0.
- CHECK (1 cycle): compute expected values from the registered operands, with bb = sub ? ~b : b.
  - {carry, result} = {1'b0,a} + {1'b0,bb} + sub, i.e. 33-bit.
  - zero = (result == 0).
  - overflow = (a[31] == bb[31]) && (result[31] != a[31]).
  - Compare all four fields with the ALU outputs.
  - On any mismatch: increment err_count (saturating). If it is the first error, latch fail_index=i and fail_mask.
  - vec_count increments.
  - If vec_count+1 == NUM_VECTORS, go to DONE; otherwise go to DRIVE.
- DONE: busy=0, done=1. alu_* outputs hold the last vector.
- Latency: 2+CHECK_DELAY cycles per vector. done rises NUM_VECTORS*(2+CHECK_DELAY) cycles after the start-sampling edge.
- The sequence is fully deterministic; identical runs produce identical vectors.

Optional Feature:
ALU32_STOP_ON_FAIL_EN:
- Defined: the first mismatch in CHECK goes directly to DONE after latching the fail fields. vec_count includes the failing vector.
- Undefined: the run always completes all NUM_VECTORS; only the first failure is captured.

Test Plan:
1. Golden ALU model attached, NUM_VECTORS=16, CHECK_DELAY=1, start pulse.
   - done rises 48 cycles later.
   - pass=1, vec_count=16, err_count=0, busy=0.
2. Corner vectors on alu_* must match:
   - i=1: expected 32'h80000000, overflow=1, carry=0.
   - i=2: expected 32'h7FFFFFFF, overflow=1, carry=1.
   - i=3: expected 0, zero=1, carry=1, overflow=0.
   - i=0: zero=1, carry=0.
3. ALU zero flag stuck at 0, NUM_VECTORS=16.
   - done after full run; err_count=2 (vectors 0 and 3).
   - fail_index=0, fail_mask=4'b0010, pass=0.
4. Same fault with ALU32_STOP_ON_FAIL_EN defined.
   - done 3 cycles after start; vec_count=1, err_count=1, fail_index=0.
5. rst_n low for one cycle during WAIT of vector 5.
   - Next cycle: busy=0, done=0, all counts 0, alu_a=alu_b=0.
   - A new start reproduces the identical vector sequence from vector 0.
6. start pulsed again during a run → ignored, vec_count continues. start pulsed while in DONE → counters clear and the run restarts with the same sequence.
